// File: rtl/spi_shift_engine_if.sv
// Handshake and serial bus bundle for the SPI shift engine.
// The engine is the SPI master; the "master" modport is the engine side,
// the "slave" modport is whatever feeds words in and the SPI slave behind it.
interface spi_shift_engine_if;
    logic [31:0] tx_data_i;
    logic        tx_vld_i;
    logic        tx_rdy_o;
    logic [31:0] rx_data_o;
    logic        rx_vld_o;
    logic        rx_rdy_i;
    logic        sclk_o;
    logic        mosi_o;
    logic        miso_i;
    logic        ss_n_o;
    logic        busy_o;

    modport master (
        input  tx_data_i, tx_vld_i, rx_rdy_i, miso_i,
        output tx_rdy_o, rx_data_o, rx_vld_o, sclk_o, mosi_o, ss_n_o, busy_o
    );

    modport slave (
        output tx_data_i, tx_vld_i, rx_rdy_i, miso_i,
        input  tx_rdy_o, rx_data_o, rx_vld_o, sclk_o, mosi_o, ss_n_o, busy_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// 32-bit SPI master shift engine, MSB first, all four CPOL/CPHA modes.
// One word per transfer: SETUP (ss_n low, first bit on mosi), SHIFT (64 SCLK
// edges), HOLD (ss_n still low), DONE (ss_n high, rx word published).
module spi_shift_engine #(
    parameter int unsigned CLK_DIV = 2,    // SCLK half-period in clk_i cycles, 1..255
    parameter bit          CPOL    = 1'b0, // idle level of sclk_o
    parameter bit          CPHA    = 1'b0  // 0: sample on leading edge, 1: on trailing edge
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    spi_shift_engine_if.master    bus
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    state_e      state_q;
    logic [7:0]  div_q;     // cycles left until the next SCLK edge / phase end
    logic [5:0]  edge_q;    // SCLK edge index 0..63; edge_q[5:1] is the bit number
    logic [31:0] shift_q;
    logic        samp_q;    // latest miso sample, merged into shift_q on the next drive
    logic        sclk_q;
    logic        mosi_q;
    logic        ss_n_q;
    logic [31:0] rx_data_q;
    logic        rx_vld_q;

    logic accept;
    logic div_zero;
    logic samp_edge;
    logic last_edge;

    assign bus.tx_rdy_o  = (state_q == IDLE) && (!rx_vld_q || bus.rx_rdy_i);
    assign accept        = bus.tx_vld_i && bus.tx_rdy_o;
    assign div_zero      = (div_q == 8'd0);
    // Even edge indices are leading edges; the sampling edge depends on CPHA.
    assign samp_edge     = (edge_q[0] == CPHA);
    assign last_edge     = (edge_q == 6'd63);

    assign bus.sclk_o    = sclk_q;
    assign bus.mosi_o    = mosi_q;
    assign bus.ss_n_o    = ss_n_q;
    assign bus.rx_data_o = rx_data_q;
    assign bus.rx_vld_o  = rx_vld_q;
    assign bus.busy_o    = (state_q != IDLE);

    // Transfer FSM with divider, edge counter, shift register and registered pins.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            edge_q    <= 6'd0;
            shift_q   <= 32'd0;
            samp_q    <= 1'b0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            rx_data_q <= 32'd0;
            rx_vld_q  <= 1'b0;
        end else begin
            if (rx_vld_q && bus.rx_rdy_i)
                rx_vld_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= bus.tx_data_i;
                        mosi_q  <= bus.tx_data_i[31];
                        ss_n_q  <= 1'b0;
                        sclk_q  <= CPOL;
                        div_q   <= DIV_RELOAD;
                        edge_q  <= 6'd0;
                        samp_q  <= 1'b0;
                        state_q <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_zero) begin
                        div_q   <= DIV_RELOAD;
                        state_q <= SHIFT;
                    end else begin
                        div_q   <= div_q - 8'd1;
                    end
                end

                SHIFT: begin
                    if (div_zero) begin
                        div_q  <= DIV_RELOAD;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 6'd1;
                        if (samp_edge) begin
                            samp_q <= bus.miso_i;
                        end else if (CPHA && edge_q == 6'd0) begin
                            // First CPHA=1 edge only presents bit 31; nothing sampled yet.
                            mosi_q <= shift_q[31];
                        end else if (!last_edge) begin
                            // Holding the sample one drive back keeps the outgoing
                            // LSB intact until it has been shifted out.
                            shift_q <= {shift_q[30:0], samp_q};
                            mosi_q  <= shift_q[30];
                        end
                        if (last_edge)
                            state_q <= HOLD;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end

                HOLD: begin
                    if (div_zero) begin
                        ss_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        div_q   <= div_q - 8'd1;
                    end
                end

                DONE: begin
                    rx_data_q <= {shift_q[30:0], samp_q};
                    rx_vld_q  <= 1'b1;
                    mosi_q    <= 1'b0;
                    state_q   <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: five instances (four CPOL/CPHA modes at
// CLK_DIV=2, plus CLK_DIV=1), each with a behavioural SPI slave or loopback.
module tb_spi_shift_engine;

    localparam int       NI        = 5;
    localparam int       DIVS [NI] = '{2, 2, 2, 2, 1};
    localparam bit [4:0] POLS      = 5'b01100;
    localparam bit [4:0] CPHAS     = 5'b01010;

    logic clk = 1'b0;
    logic rstn;

    logic [NI-1:0]        tx_vld, tx_rdy, rx_vld, rx_rdy, sclk, mosi, miso, ss_n, busy, loopb;
    logic [NI-1:0][31:0]  tx_data, rx_data, slv_word, slv_got;
    logic [NI-1:0][7:0]   rises_v;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_shift_engine_if u_if ();

        spi_shift_engine #(.CLK_DIV(DIVS[g]), .CPOL(POLS[g]), .CPHA(CPHAS[g])) u_dut (
            .clk_i  (clk),
            .rstn_i (rstn),
            .bus    (u_if)
        );

        assign u_if.tx_data_i = tx_data[g];
        assign u_if.tx_vld_i  = tx_vld[g];
        assign u_if.rx_rdy_i  = rx_rdy[g];
        assign u_if.miso_i    = miso[g];
        assign tx_rdy[g]      = u_if.tx_rdy_o;
        assign rx_data[g]     = u_if.rx_data_o;
        assign rx_vld[g]      = u_if.rx_vld_o;
        assign sclk[g]        = u_if.sclk_o;
        assign mosi[g]        = u_if.mosi_o;
        assign ss_n[g]        = u_if.ss_n_o;
        assign busy[g]        = u_if.busy_o;

        logic [31:0] s_tx = 32'd0;
        logic [31:0] s_rx = 32'd0;
        logic        s_miso = 1'b0;
        logic        ss_prev = 1'b1;
        logic        sclk_prev = POLS[g];
        logic [7:0]  rises = 8'd0;
        int          s_cnt = 0;

        assign miso[g]    = loopb[g] ? mosi[g] : s_miso;
        assign slv_got[g] = s_rx;
        assign rises_v[g] = rises;

        // Behavioural SPI slave: shifts slv_word out, collects mosi, counts SCLK rises.
        always @(sclk[g] or ss_n[g]) begin
            if (ss_n[g] !== ss_prev) begin
                ss_prev = ss_n[g];
                if (!ss_n[g]) begin
                    s_tx   = slv_word[g];
                    s_rx   = 32'd0;
                    s_miso = s_tx[31];
                    s_cnt  = 0;
                    rises  = 8'd0;
                end
            end
            if (sclk[g] !== sclk_prev) begin
                sclk_prev = sclk[g];
                if (!ss_n[g]) begin
                    if (sclk[g]) rises = rises + 8'd1;
                    if ((sclk[g] != POLS[g]) != CPHAS[g]) begin
                        s_rx = {s_rx[30:0], mosi[g]};
                    end else if (!(CPHAS[g] && s_cnt == 0)) begin
                        s_tx   = {s_tx[30:0], 1'b0};
                        s_miso = s_tx[31];
                    end
                    s_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int i, input logic [31:0] w, input bit push, input logic [31:0] rx_exp);
        int n;
        n = 0;
        while (!tx_rdy[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_rdy[i]) chk("tx_rdy_timeout", 32'(tx_rdy[i]), 32'd1);
        tx_data[i] = w;
        tx_vld[i]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_vld[i]  = 1'b0;
        if (push) exp_q.push_back(rx_exp);
    endtask

    // lat counts cycles from the accept cycle (index 0) to the first cycle with rx_vld high.
    task automatic wait_rx(input int i, input string tag, output int lat, output int tog);
        logic        prev;
        logic [31:0] e;
        prev = sclk[i];
        lat  = 1;
        tog  = 0;
        while (!rx_vld[i] && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (sclk[i] !== prev) tog++;
            prev = sclk[i];
        end
        if (!rx_vld[i]) begin
            chk({tag, "_timeout"}, 32'(rx_vld[i]), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rx_data[i], e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, tog;
        logic [31:0] held;
        logic [31:0] words [3];

        rstn     = 1'b0;
        tx_vld   = '0;
        tx_data  = '0;
        rx_rdy   = '1;
        loopb    = 5'b10001;
        for (int k = 0; k < NI; k++) slv_word[k] = 32'h5A5AC3C3;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ss_n",   32'(ss_n),   32'h1f);
        chk("rst_sclk",   32'(sclk),   32'(POLS));
        chk("rst_mosi",   32'(mosi),   32'd0);
        chk("rst_rx_vld", 32'(rx_vld), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_tx_rdy", 32'(tx_rdy), 32'h1f);
        chk("rst_rx_data", rx_data[0], 32'd0);

        // Loopback, mode 0, CLK_DIV=2
        send(0, 32'hA5A51234, 1'b1, 32'hA5A51234);
        chk("ss_low_after_accept", 32'(ss_n[0]), 32'd0);
        chk("busy_after_accept",   32'(busy[0]), 32'd1);
        chk("setup_mosi_bit31",    32'(mosi[0]), 32'd1);
        wait_rx(0, "loop_data", lat, tog);
        chk("loop_latency", 32'(lat), 32'd134);
        chk("loop_rises",   32'(rises_v[0]), 32'd32);
        chk("loop_sclk_idle", 32'(sclk[0]), 32'd0);

        // All four modes against the slave model
        loopb[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(i, 32'hDEADBEEF, 1'b1, 32'h5A5AC3C3);
            wait_rx(i, "mode_rx_data", lat, tog);
            chk("mode_slave_rx", slv_got[i], 32'hDEADBEEF);
            chk("mode_sclk_idle", 32'(sclk[i]), 32'(POLS[i]));
            chk("mode_latency", 32'(lat), 32'd134);
        end
        loopb[0] = 1'b1;

        // Back-pressure: rx word held, second word blocked until consumed
        rx_rdy[0] = 1'b0;
        send(0, 32'h3C3C0F0F, 1'b1, 32'h3C3C0F0F);
        wait_rx(0, "bp_first", lat, tog);
        held       = rx_data[0];
        tx_data[0] = 32'h13579BDF;
        tx_vld[0]  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_tx_rdy_low", 32'(tx_rdy[0]), 32'd0);
            chk("bp_rx_stable",  rx_data[0], held);
            chk("bp_rx_vld",     32'(rx_vld[0]), 32'd1);
        end
        rx_rdy[0] = 1'b1;
        #1;
        chk("bp_tx_rdy_rise", 32'(tx_rdy[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_vld[0] = 1'b0;
        exp_q.push_back(32'h13579BDF);
        chk("bp_rx_consumed", 32'(rx_vld[0]), 32'd0);
        chk("bp_second_busy", 32'(busy[0]),   32'd1);
        wait_rx(0, "bp_second", lat, tog);

        // Back-to-back words
        words[0] = 32'h00000001;
        words[1] = 32'h80000000;
        words[2] = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            send(0, words[k], 1'b1, words[k]);
            wait_rx(0, "b2b_data", lat, tog);
            chk("b2b_latency", 32'(lat), 32'd134);
            chk("b2b_ss_gap",  32'(ss_n[0]), 32'd1);
        end

        // Reset during SHIFT around bit 17
        send(0, 32'hCAFEF00D, 1'b0, 32'd0);
        repeat (69) @(negedge clk);
        chk("rst_mid_busy", 32'(busy[0]), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_ss_n",   32'(ss_n[0]),   32'd1);
        chk("rst_mid_rx_vld", 32'(rx_vld[0]), 32'd0);
        chk("rst_mid_busy0",  32'(busy[0]),   32'd0);
        chk("rst_mid_sclk",   32'(sclk[0]),   32'd0);
        chk("rst_mid_mosi",   32'(mosi[0]),   32'd0);
        chk("rst_mid_rxdata", rx_data[0],     32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_rx", 32'(rx_vld[0]), 32'd0);
        send(0, 32'h0000FFFF, 1'b1, 32'h0000FFFF);
        wait_rx(0, "post_rst_data", lat, tog);
        chk("post_rst_latency", 32'(lat), 32'd134);

        // CLK_DIV=1 loopback
        send(4, 32'h12345678, 1'b1, 32'h12345678);
        wait_rx(4, "div1_data", lat, tog);
        chk("div1_latency", 32'(lat), 32'd68);
        chk("div1_toggles", 32'(tog), 32'd64);
        chk("div1_rises",   32'(rises_v[4]), 32'd32);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
